frame_sequencer: RTL and testbench



---
 rtl/frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_frame_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// ----------------------------------------------------------------------------
// frame_sequencer
//   Frame counter for the tone channels. A free-running divider splits time
//   into steps of STEP_CYCLES clocks. At each step boundary the sequencer
//   emits the quarter-frame (enable_240hz) and half-frame (enable_120hz)
//   strobes and, in 4-step mode, raises the frame interrupt at the end of
//   the frame.
//
// Ports
//   clk            : system clock (CPU rate)
//   rst_n          : synchronous reset, active-low
//   reg_4017       : frame counter data, bit7 = 5-step mode, bit6 = irq inhibit
//   reg_4017_event : one-cycle strobe, reg_4017 written this cycle
//   status_read    : one-cycle strobe, status read (clears frame IRQ)
//   enable_240hz   : quarter-frame strobe, registered, one clk wide
//   enable_120hz   : half-frame strobe, registered, one clk wide
//   frame_irq      : sticky frame interrupt flag, registered
//   step           : current step index (0..3 or 0..4)
// ----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int unsigned STEP_CYCLES = 7457,
    parameter int unsigned DIV_WIDTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] reg_4017,
    input  logic       reg_4017_event,
    input  logic       status_read,
    output logic       enable_240hz,
    output logic       enable_120hz,
    output logic       frame_irq,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        STEP0 = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4
    } step_t;

    localparam logic [DIV_WIDTH-1:0] LP_TERMINAL = DIV_WIDTH'(STEP_CYCLES - 1);

    logic [DIV_WIDTH-1:0] r_div;
    step_t                r_step;
    logic                 r_mode;
    logic                 r_inhibit;
    logic                 r_q;
    logic                 r_h;
    logic                 r_irq;

    logic [DIV_WIDTH-1:0] w_div_next;
    step_t                w_step_next;
    logic                 w_mode_next;
    logic                 w_inhibit_next;
    logic                 w_q_next;
    logic                 w_h_next;
    logic                 w_irq_set;
    logic                 w_irq_next;
    logic                 w_terminal;
    logic                 w_last_step;
    logic                 w_unused;

    // Only the mode and inhibit bits of the register are meaningful.
    assign w_unused = ^reg_4017[5:0];

    assign w_terminal  = (r_div == LP_TERMINAL);
    assign w_last_step = r_mode ? (r_step == STEP4) : (r_step == STEP3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_step    <= STEP0;
            r_mode    <= 1'b0;
            r_inhibit <= 1'b0;
            r_q       <= 1'b0;
            r_h       <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_step    <= w_step_next;
            r_mode    <= w_mode_next;
            r_inhibit <= w_inhibit_next;
            r_q       <= w_q_next;
            r_h       <= w_h_next;
            r_irq     <= w_irq_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: divider, step index and latched register bits
    // ------------------------------------------------------------------
    always_comb begin
        w_div_next     = r_div + DIV_WIDTH'(1);
        w_step_next    = r_step;
        w_mode_next    = r_mode;
        w_inhibit_next = r_inhibit;

        if (reg_4017_event) begin
            // A write restarts the frame from step 0 in the new mode,
            // overriding any step boundary landing on the same edge.
            w_mode_next    = reg_4017[7];
            w_inhibit_next = reg_4017[6];
            w_div_next     = '0;
            w_step_next    = STEP0;
        end else if (w_terminal) begin
            w_div_next = '0;
            if (w_last_step) begin
                w_step_next = STEP0;
            end else begin
                unique case (r_step)
                    STEP0:   w_step_next = STEP1;
                    STEP1:   w_step_next = STEP2;
                    STEP2:   w_step_next = STEP3;
                    STEP3:   w_step_next = STEP4;
                    default: w_step_next = STEP0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic: strobe and interrupt values for the next cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_q_next  = 1'b0;
        w_h_next  = 1'b0;
        w_irq_set = 1'b0;

        if (reg_4017_event) begin
            // Entering 5-step mode clocks both units immediately.
            w_q_next = reg_4017[7];
            w_h_next = reg_4017[7];
        end else if (w_terminal) begin
            // r_step is the step just completing (n = r_step + 1).
            unique case (r_step)
                STEP0: w_q_next = 1'b1;
                STEP1: begin
                    w_q_next = 1'b1;
                    w_h_next = 1'b1;
                end
                STEP2: w_q_next = 1'b1;
                STEP3: begin
                    // 4-step frame end; in 5-step mode this step is silent.
                    if (!r_mode) begin
                        w_q_next  = 1'b1;
                        w_h_next  = 1'b1;
                        w_irq_set = !r_inhibit;
                    end
                end
                STEP4: begin
                    w_q_next = 1'b1;
                    w_h_next = 1'b1;
                end
                default: ;
            endcase
        end

        // A set on the same edge as a status read wins over the clear.
        if (reg_4017_event && reg_4017[6]) begin
            w_irq_next = 1'b0;
        end else if (w_irq_set) begin
            w_irq_next = 1'b1;
        end else if (status_read) begin
            w_irq_next = 1'b0;
        end else begin
            w_irq_next = r_irq;
        end
    end

    assign enable_240hz = r_q;
    assign enable_120hz = r_h;
    assign frame_irq    = r_irq;
    assign step         = r_step;

endmodule

// File: tb/tb_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_frame_sequencer
//   Directed scenarios followed by randomized traffic for frame_sequencer
//   with a short step length. The reference model tracks elapsed cycles
//   since the last reset or register write and derives strobes, step and
//   interrupt from that count with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int SC = 10;

    logic       clk;
    logic       rst_n;
    logic [7:0] reg_4017;
    logic       reg_4017_event;
    logic       status_read;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       frame_irq;
    logic [2:0] step;

    int n_cmp;
    int n_fail;

    // Reference model state
    int   m_t;
    logic m_mode;
    logic m_inh;
    logic m_q;
    logic m_h;
    logic m_irq;
    int   m_step;

    frame_sequencer #(
        .STEP_CYCLES(SC),
        .DIV_WIDTH  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_4017      (reg_4017),
        .reg_4017_event(reg_4017_event),
        .status_read   (status_read),
        .enable_240hz  (enable_240hz),
        .enable_120hz  (enable_120hz),
        .frame_irq     (frame_irq),
        .step          (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input logic r, input logic w, input logic [7:0] d, input logic s);
        int  nst;
        int  k;
        bit  set;
        if (!r) begin
            m_t = 0; m_mode = 0; m_inh = 0;
            m_q = 0; m_h = 0; m_irq = 0;
        end else if (w) begin
            m_mode = d[7];
            m_inh  = d[6];
            m_t    = 0;
            m_q    = d[7];
            m_h    = d[7];
            if (d[6] || s) m_irq = 0;
        end else begin
            m_t = m_t + 1;
            m_q = 0; m_h = 0; set = 0;
            nst = m_mode ? 5 : 4;
            if (m_t % SC == 0) begin
                k   = ((m_t / SC - 1) % nst) + 1;
                m_q = !(m_mode && k == 4);
                m_h = (k == 2) || (k == nst);
                set = !m_mode && (k == 4) && !m_inh;
            end
            if (set) m_irq = 1;
            else if (s) m_irq = 0;
        end
        nst    = m_mode ? 5 : 4;
        m_step = (m_t / SC) % nst;
    endtask

    task automatic tick(input logic r, input logic w, input logic [7:0] d, input logic s);
        rst_n          = r;
        reg_4017_event = w;
        reg_4017       = d;
        status_read    = s;
        @(posedge clk);
        model_edge(r, w, d, s);
        #1;
        check("q",    {7'd0, enable_240hz}, {7'd0, m_q});
        check("h",    {7'd0, enable_120hz}, {7'd0, m_h});
        check("irq",  {7'd0, frame_irq},    {7'd0, m_irq});
        check("step", {5'd0, step},         8'(m_step));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n = 1'b0; reg_4017 = 8'h00; reg_4017_event = 1'b0; status_read = 1'b0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_q",   {7'd0, enable_240hz}, 8'h00);
        check("rst_irq", {7'd0, frame_irq},    8'h00);

        // 4-step free run: IRQ rises after edge 40, step back at 0
        run(40);
        check("irq_40",  {7'd0, frame_irq},    8'h01);
        check("q_40",    {7'd0, enable_240hz}, 8'h01);
        check("step_40", {5'd0, step},         8'h00);
        run(45);

        // 5-step write at cycle 15
        do_reset();
        run(15);
        tick(1'b1, 1'b1, 8'h80, 1'b0);
        check("wr5_q", {7'd0, enable_240hz}, 8'h01);
        check("wr5_h", {7'd0, enable_120hz}, 8'h01);
        run(40);
        check("m5_silent_q", {7'd0, enable_240hz}, 8'h00);
        run(10);
        check("m5_50_h", {7'd0, enable_120hz}, 8'h01);
        run(60);
        check("m5_irq", {7'd0, frame_irq}, 8'h00);

        // IRQ clear by status read, then by inhibit write
        do_reset();
        run(40);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        check("sr_clr", {7'd0, frame_irq}, 8'h00);
        run(40);
        check("irq_again", {7'd0, frame_irq}, 8'h01);
        tick(1'b1, 1'b1, 8'h40, 1'b0);
        check("inh_clr", {7'd0, frame_irq}, 8'h00);
        run(45);
        check("inh_hold", {7'd0, frame_irq}, 8'h00);

        // Status read coincident with IRQ set
        do_reset();
        run(39);
        tick(1'b1, 1'b0, 8'h00, 1'b1);
        check("collide", {7'd0, frame_irq}, 8'h01);

        // Write on the terminal cycle of step 2
        do_reset();
        run(19);
        tick(1'b1, 1'b1, 8'h00, 1'b0);
        check("wterm_q",    {7'd0, enable_240hz}, 8'h00);
        check("wterm_step", {5'd0, step},         8'h00);
        run(9);
        check("wterm_q9",  {7'd0, enable_240hz}, 8'h00);
        run(1);
        check("wterm_q10", {7'd0, enable_240hz}, 8'h01);

        // Reset mid-step: divider 7, step 3, IRQ set
        do_reset();
        run(77);
        check("pre_irq",  {7'd0, frame_irq}, 8'h01);
        check("pre_step", {5'd0, step},      8'h03);
        do_reset();
        check("mid_irq",  {7'd0, frame_irq}, 8'h00);
        check("mid_step", {5'd0, step},      8'h00);
        run(9);
        check("mid_q9", {7'd0, enable_240hz}, 8'h00);
        run(1);
        check("mid_q10", {7'd0, enable_240hz}, 8'h01);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, w, s;
            logic [7:0] d;
            r = ($urandom_range(0, 199) != 0);
            w = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 19) == 0);
            d = 8'($urandom);
            tick(r, w, d, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
